// File: rtl/dbf_chan_dynfocus_pkg.sv
// Shared widths, FSM encodings and the round/saturate helper for the
// dynamic-focus DBF receive channel.
package dbf_chan_dynfocus_pkg;

  localparam int DEF_INPUT_WD = 14;
  localparam int DEF_APO_WD   = 16;
  localparam int DEF_OUT_WD   = 16;
  localparam int DEF_DLY_WD   = 8;
  localparam int DEF_ADDR_WD  = 6;
  localparam int DEF_ZONE_LEN = 64;
  localparam int DEF_SHIFT    = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Round half up, arithmetic shift, then clamp to a signed out_wd range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] prod,
                                                   input int shift,
                                                   input int out_wd);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (shift > 0) r = (prod + (64'sd1 <<< (shift - 1))) >>> shift;
    else r = prod;
    hi = (64'sd1 <<< (out_wd - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_wd - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/dbf_delay_ram.sv
// Simple dual-port synchronous RAM, read-first on a same-address collision.
// Only the read register is reset; the array contents are not.
module dbf_delay_ram
  import dbf_chan_dynfocus_pkg::*;
#(
  parameter int DATA_WD = 14,
  parameter int ADDR_WD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADDR_WD-1:0] waddr,
  input  logic [DATA_WD-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_WD-1:0] raddr,
  output logic [DATA_WD-1:0] rdata
);

  logic [DATA_WD-1:0] mem [0:(1<<ADDR_WD)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dbf_chan_dynfocus.sv
// DBF receive channel: circular coarse-delay buffer with per-zone delays from
// a host-loaded LUT, followed by apodisation, rounding and saturation.
module dbf_chan_dynfocus
  import dbf_chan_dynfocus_pkg::*;
#(
  parameter int INPUT_WD = DEF_INPUT_WD,
  parameter int APO_WD   = DEF_APO_WD,
  parameter int OUT_WD   = DEF_OUT_WD,
  parameter int DLY_WD   = DEF_DLY_WD,
  parameter int ADDR_WD  = DEF_ADDR_WD,
  parameter int ZONE_LEN = DEF_ZONE_LEN,
  parameter int SHIFT    = DEF_SHIFT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_en,
  input  logic                start,
  input  logic [INPUT_WD-1:0] ch_in,
  input  logic [APO_WD-1:0]   apo_din,
  input  logic [ADDR_WD-1:0]  lut_addr,
  input  logic                lut_we,
  input  logic [DLY_WD-1:0]   lut_din,
  output logic [OUT_WD-1:0]   dbf_ch_dout,
  output logic                dbf_ch_dout_valid,
  output logic [INPUT_WD-1:0] cd_dout,
  output logic [ADDR_WD-1:0]  zone_idx
);

  localparam int DEPTH   = 1 << DLY_WD;
  localparam int ZC_WD   = $clog2(ZONE_LEN);
  localparam int PROD_WD = INPUT_WD + APO_WD;
  localparam logic [ZC_WD-1:0]  ZC_LAST  = ZC_WD'(ZONE_LEN - 1);
  localparam logic [ZC_WD-1:0]  ZC_PRE   = ZC_WD'(ZONE_LEN - 2);
  localparam logic [ZC_WD-1:0]  ZC_ONE   = ZC_WD'(1);
  localparam logic [DLY_WD-1:0] PTR_ONE  = DLY_WD'(1);
  localparam logic [DLY_WD:0]   FILL_MAX = (DLY_WD+1)'(DEPTH);
  localparam logic [DLY_WD:0]   FILL_ONE = (DLY_WD+1)'(1);

  logic [1:0]                 state;
  logic [DLY_WD-1:0]          wr_ptr;
  logic [DLY_WD-1:0]          rd_addr;
  logic [DLY_WD-1:0]          d_cur;
  logic [DLY_WD:0]            fill;
  logic [ZC_WD-1:0]           zcnt;
  logic [ADDR_WD-1:0]         next_zone;
  logic                       acc;
  logic                       zone_wrap;
  logic                       prefetch;
  logic                       stage1;
  logic                       lut_re;
  logic [ADDR_WD-1:0]         lut_raddr;
  logic [DLY_WD-1:0]          lut_q;
  logic [INPUT_WD-1:0]        ram_q;
  logic [INPUT_WD-1:0]        byp_data;
  logic                       byp_sel;
  logic signed [INPUT_WD-1:0] cd_s;
  logic signed [APO_WD-1:0]   apo_r;
  logic signed [PROD_WD-1:0]  prod;
  logic signed [63:0]         prod_ext;
  logic                       v1;
  logic                       v2;

  assign acc       = (state == ST_RUN) & ~tx_en;
  assign zone_wrap = acc & (zcnt == ZC_LAST);
  assign prefetch  = acc & (zcnt == ZC_PRE);
  assign next_zone = (zone_idx == '1) ? zone_idx : zone_idx + ADDR_WD'(1);
  assign rd_addr   = wr_ptr - d_cur;
  // fill counts samples before this one; with this one included it must exceed D.
  assign stage1    = acc & start & ({1'b0, d_cur} <= fill);

  // Zone 0 is read while leaving IDLE so LOAD can latch it; later zones are
  // prefetched one accept before the wrap.
  assign lut_raddr = (state == ST_IDLE) ? '0 : next_zone;
  assign lut_re    = ((state == ST_IDLE) & start) | prefetch;

  // D=0 reads the slot being written this cycle, so bypass the read-first RAM.
  assign cd_dout  = byp_sel ? byp_data : ram_q;
  assign cd_s     = cd_dout;
  assign prod_ext = {{(64-PROD_WD){prod[PROD_WD-1]}}, prod};

  dbf_delay_ram #(.DATA_WD(INPUT_WD), .ADDR_WD(DLY_WD)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (acc),
    .waddr (wr_ptr),
    .wdata (ch_in),
    .re    (acc),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  dbf_delay_ram #(.DATA_WD(DLY_WD), .ADDR_WD(ADDR_WD)) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_we),
    .waddr (lut_addr),
    .wdata (lut_din),
    .re    (lut_re),
    .raddr (lut_raddr),
    .rdata (lut_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_LOAD;
        ST_LOAD: state <= start ? ST_RUN : ST_IDLE;
        ST_RUN:  if (!start) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill     <= '0;
      zcnt     <= '0;
      zone_idx <= '0;
      d_cur    <= '0;
    end else if (state == ST_IDLE) begin
      wr_ptr   <= '0;
      fill     <= '0;
      zcnt     <= '0;
      zone_idx <= '0;
    end else begin
      if (state == ST_LOAD) d_cur <= lut_q;
      if (acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (fill != FILL_MAX) fill <= fill + FILL_ONE;
        if (zone_wrap) begin
          zcnt     <= '0;
          zone_idx <= next_zone;
          d_cur    <= lut_q;
        end else begin
          zcnt <= zcnt + ZC_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_sel           <= 1'b0;
      byp_data          <= '0;
      apo_r             <= '0;
      v1                <= 1'b0;
      v2                <= 1'b0;
      prod              <= '0;
      dbf_ch_dout       <= '0;
      dbf_ch_dout_valid <= 1'b0;
    end else begin
      if (acc) begin
        byp_sel  <= (d_cur == '0);
        byp_data <= ch_in;
        apo_r    <= apo_din;
      end
      v1                <= stage1;
      v2                <= v1 & start;
      dbf_ch_dout_valid <= v2 & start;
      if (v1) prod <= cd_s * apo_r;
      if (v2 & start) dbf_ch_dout <= OUT_WD'(round_sat(prod_ext, SHIFT, OUT_WD));
    end
  end

endmodule

// File: tb/tb_dbf_chan_dynfocus.sv
// Directed bench for dbf_chan_dynfocus: apodisation vector table plus
// delay, zone, tx gap, abort, async reset and LUT collision sequences.
module tb_dbf_chan_dynfocus;

  localparam int INPUT_WD = 14;
  localparam int APO_WD   = 16;
  localparam int OUT_WD   = 12;
  localparam int DLY_WD   = 8;
  localparam int ADDR_WD  = 6;
  localparam int ZONE_LEN = 64;
  localparam int SHIFT    = 15;
  localparam int NZONES   = 1 << ADDR_WD;
  localparam int DEPTH    = 1 << DLY_WD;

  typedef struct {
    int ch;
    int apo;
    int exp;
  } vec_t;

  logic                clk;
  logic                rst_n;
  logic                tx_en;
  logic                start;
  logic [INPUT_WD-1:0] ch_in;
  logic [APO_WD-1:0]   apo_din;
  logic [ADDR_WD-1:0]  lut_addr;
  logic                lut_we;
  logic [DLY_WD-1:0]   lut_din;
  logic [OUT_WD-1:0]   dbf_ch_dout;
  logic                dbf_ch_dout_valid;
  logic [INPUT_WD-1:0] cd_dout;
  logic [ADDR_WD-1:0]  zone_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_valid_cyc = -1;
  int k5_cyc = 0;
  bit mon_en = 1'b1;
  logic [OUT_WD-1:0] exp_q[$];
  logic [DLY_WD-1:0] lut_model[NZONES];
  vec_t vecs[12];

  dbf_chan_dynfocus #(
    .INPUT_WD (INPUT_WD),
    .APO_WD   (APO_WD),
    .OUT_WD   (OUT_WD),
    .DLY_WD   (DLY_WD),
    .ADDR_WD  (ADDR_WD),
    .ZONE_LEN (ZONE_LEN),
    .SHIFT    (SHIFT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tx_en             (tx_en),
    .start             (start),
    .ch_in             (ch_in),
    .apo_din           (apo_din),
    .lut_addr          (lut_addr),
    .lut_we            (lut_we),
    .lut_din           (lut_din),
    .dbf_ch_dout       (dbf_ch_dout),
    .dbf_ch_dout_valid (dbf_ch_dout_valid),
    .cd_dout           (cd_dout),
    .zone_idx          (zone_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: inputs change at the falling edge, outputs are sampled there too.
  task automatic step();
    logic [OUT_WD-1:0] e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (mon_en && dbf_ch_dout_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got dout %0d with no expected entry (cycle %0d)",
                 $signed(dbf_ch_dout), cyc);
      end else begin
        e = exp_q.pop_front();
        check("dout", $signed(dbf_ch_dout), $signed(e));
      end
    end
  endtask

  task automatic lut_write(input int addr, input int val);
    lut_addr = ADDR_WD'(addr);
    lut_din  = DLY_WD'(val);
    lut_we   = 1'b1;
    step();
    lut_we = 1'b0;
    lut_model[addr] = DLY_WD'(val);
  endtask

  task automatic lut_fill(input int d0, input int d1, input int dmid, input int dlast);
    for (int z = 0; z < NZONES; z++)
      lut_write(z, (z == 0) ? d0 : (z == 1) ? d1 : (z == NZONES - 1) ? dlast : dmid);
  endtask

  task automatic begin_line();
    start  = 1'b1;
    tx_en  = 1'b0;
    step();
    step();
    first_valid_cyc = -1;
  endtask

  // Drain with tx_en high, confirm the outputs hold, then drop start.
  task automatic end_line(input int last_exp, input int last_cd);
    tx_en = 1'b1;
    repeat (5) step();
    check("drain_empty", exp_q.size(), 0);
    check("hold_dout", $signed(dbf_ch_dout), last_exp);
    check("hold_cd", $signed(cd_dout), last_cd);
    start = 1'b0;
    tx_en = 1'b0;
    step();
    step();
  endtask

  function automatic int rv(input int base, input int k);
    return base + (k % 1500);
  endfunction

  // Ramp line with apo=0x7FFF (output equals the delayed sample for these magnitudes).
  task automatic run_ramp(input int n, input int base, input int wr_k, input int wr_addr,
                          input int wr_val, output int last_exp);
    logic [DLY_WD-1:0] line_d[NZONES];
    int z;
    int d;
    int fill;
    int prev_exp;
    bit prev_ok;
    line_d   = lut_model;
    prev_ok  = 1'b0;
    prev_exp = 0;
    last_exp = 0;
    for (int k = 0; k < n; k++) begin
      z = k / ZONE_LEN;
      if (z > NZONES - 1) z = NZONES - 1;
      if ((k % ZONE_LEN) == 0 || k == n - 1) check("zone_idx", zone_idx, z);
      if (prev_ok) check("cd_dout", $signed(cd_dout), prev_exp);
      ch_in   = INPUT_WD'(rv(base, k));
      apo_din = 16'h7FFF;
      if (k == wr_k) begin
        lut_we   = 1'b1;
        lut_addr = ADDR_WD'(wr_addr);
        lut_din  = DLY_WD'(wr_val);
        lut_model[wr_addr] = DLY_WD'(wr_val);
      end
      if (k == 5) k5_cyc = cyc;
      d    = int'(line_d[z]);
      fill = (k < DEPTH) ? k : DEPTH;
      prev_ok = (fill >= d);
      if (prev_ok) begin
        prev_exp = rv(base, k - d);
        exp_q.push_back(OUT_WD'(prev_exp));
        last_exp = prev_exp;
      end
      step();
      lut_we = 1'b0;
    end
  endtask

  initial begin
    int last;
    int ax[$];
    int nvalid;

    vecs[0]  = '{8191, 32767, 2047};
    vecs[1]  = '{-8192, 32767, -2048};
    vecs[2]  = '{1, 16384, 1};
    vecs[3]  = '{-1, 16384, 0};
    vecs[4]  = '{3, 16384, 2};
    vecs[5]  = '{-3, 16384, -1};
    vecs[6]  = '{100, -32768, -100};
    vecs[7]  = '{-8192, -32768, 2047};
    vecs[8]  = '{1000, 16384, 500};
    vecs[9]  = '{2047, 32767, 2047};
    vecs[10] = '{-2048, 32767, -2048};
    vecs[11] = '{5, 0, 0};

    rst_n    = 1'b0;
    tx_en    = 1'b0;
    start    = 1'b0;
    ch_in    = '0;
    apo_din  = '0;
    lut_addr = '0;
    lut_we   = 1'b0;
    lut_din  = '0;
    repeat (3) step();
    check("rst_dout", dbf_ch_dout, 0);
    check("rst_valid", dbf_ch_dout_valid, 0);
    check("rst_cd", cd_dout, 0);
    check("rst_zone", zone_idx, 0);
    rst_n = 1'b1;
    step();

    // Fixed delay of 5 on a ramp
    lut_fill(5, 5, 5, 5);
    begin_line();
    run_ramp(30, 0, -1, 0, 0, last);
    check("first_valid_latency", first_valid_cyc - k5_cyc, 3);
    end_line(last, last);

    // Apodisation / rounding / saturation table with D=0 (write-through bypass)
    lut_fill(0, 0, 0, 0);
    begin_line();
    for (int i = 0; i < 12; i++) begin
      ch_in   = INPUT_WD'(vecs[i].ch);
      apo_din = APO_WD'(vecs[i].apo);
      exp_q.push_back(OUT_WD'(vecs[i].exp));
      step();
      check("cd_bypass", $signed(cd_dout), vecs[i].ch);
    end
    end_line(vecs[11].exp, vecs[11].ch);

    // Zone switching and zone_idx saturation
    lut_fill(10, 4, 7, 3);
    begin_line();
    run_ramp(NZONES * ZONE_LEN + 74, 0, -1, 0, 0, last);
    end_line(last, last);

    // tx_en gaps: three cycles on, three off, D=2
    lut_fill(2, 2, 2, 2);
    begin_line();
    for (int c = 0; c < 150; c++) begin
      tx_en   = (((c / 3) % 2) == 1);
      ch_in   = INPUT_WD'(300 + c);
      apo_din = 16'h7FFF;
      if (!tx_en) begin
        ax.push_back(300 + c);
        if (ax.size() >= 3) exp_q.push_back(OUT_WD'(ax[ax.size() - 3]));
      end
      step();
    end
    check("tx_zone_freeze", zone_idx, 1);
    end_line(ax[ax.size() - 3], ax[ax.size() - 3]);

    // Abort mid-line by dropping start
    lut_fill(5, 5, 5, 5);
    mon_en = 1'b0;
    begin_line();
    for (int k = 0; k < 20; k++) begin
      ch_in   = INPUT_WD'(k);
      apo_din = 16'h7FFF;
      step();
    end
    check("valid_before_abort", dbf_ch_dout_valid, 1);
    start = 1'b0;
    step();
    check("valid_after_abort", dbf_ch_dout_valid, 0);
    nvalid = 0;
    repeat (4) begin
      step();
      if (dbf_ch_dout_valid) nvalid++;
    end
    check("no_valid_after_abort", nvalid, 0);
    exp_q.delete();
    mon_en = 1'b1;
    begin_line();
    run_ramp(30, 200, -1, 0, 0, last);
    check("restart_latency", first_valid_cyc - k5_cyc, 3);
    end_line(last, last);

    // Asynchronous reset mid-line
    mon_en = 1'b0;
    begin_line();
    for (int k = 0; k < 80; k++) begin
      ch_in   = INPUT_WD'(100 + k);
      apo_din = 16'h7FFF;
      step();
    end
    check("zone_before_reset", zone_idx, 1);
    check("valid_before_reset", dbf_ch_dout_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", dbf_ch_dout, 0);
    check("async_rst_valid", dbf_ch_dout_valid, 0);
    check("async_rst_cd", cd_dout, 0);
    check("async_rst_zone", zone_idx, 0);
    start = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    exp_q.delete();
    mon_en = 1'b1;
    begin_line();
    run_ramp(20, 400, -1, 0, 0, last);
    end_line(last, last);

    // LUT write to zone 1 in the same cycle as its prefetch: read-first
    lut_fill(3, 6, 6, 6);
    begin_line();
    run_ramp(90, 0, ZONE_LEN - 2, 1, 2, last);
    end_line(last, last);
    begin_line();
    run_ramp(90, 50, -1, 0, 0, last);
    end_line(last, last);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbf_chan_dynfocus.md
Name: dbf_chan_dynfocus

Overview:
- Parametrised next-generation DBF receive channel with dynamic focusing.
- Coarse delay is a circular sample buffer. Its per-zone delay comes from a host-loaded delay LUT.
- The delayed sample is apodised (multiplied by a window coefficient), rounded and saturated.
- One instance per element; outputs feed the DBF summation tree.

Parameters:
INPUT_WD, 14, ADC sample width (signed two's complement)
APO_WD, 16, apodisation coefficient width (signed, Q1.15 at default)
OUT_WD, 16, channel output width
DLY_WD, 8, delay width; buffer depth 2^DLY_WD samples, max delay 2^DLY_WD-1
ADDR_WD, 6, zone LUT address width; 2^ADDR_WD focal zones
ZONE_LEN, 64, accepted samples per focal zone (>=2)
SHIFT, 15, right shift applied to the product before saturation

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
tx_en  in  1  transmit active; high = ch_in not accepted
start  in  1  receive-line active (level); low = idle/flush
ch_in  in  INPUT_WD  input sample, signed
apo_din  in  APO_WD  apodisation coefficient, signed, sampled with ch_in
lut_addr  in  ADDR_WD  delay LUT write address (zone index)
lut_we  in  1  delay LUT write enable
lut_din  in  DLY_WD  delay value (samples) for zone lut_addr
dbf_ch_dout  out  OUT_WD  apodised, delayed output, signed
dbf_ch_dout_valid  out  1  output valid
cd_dout  out  INPUT_WD  coarse-delayed sample (debug tap, pre-apodisation)
zone_idx  out  ADDR_WD  current focal zone

Behaviour:
- Async reset (rst_n low) clears state: dbf_ch_dout=0, dbf_ch_dout_valid=0, cd_dout=0, zone_idx=0, pointers/counters=0, FSM=IDLE. LUT and buffer RAM are not cleared; host must load the LUT before the first start.
- Accept condition: acc = (state==RUN) & ~tx_en.
- FSM IDLE:
  - Pointers, zone, zone sample count and fill count held at 0; pipeline valids 0.
  - start=1 -> LOAD.
- FSM LOAD (1 cycle):
  - Synchronous read of LUT[0] into the delay register D.
  - start=0 -> IDLE, otherwise -> RUN.
- FSM RUN:
  - On acc: write ch_in at wr_ptr; wr_ptr++ (wraps mod 2^DLY_WD); fill count increments, saturating at 2^DLY_WD.
  - Read address = wr_ptr - D (mod 2^DLY_WD).
  - Stage-1 valid = acc & (fill > D). D=0 returns the current sample via write-through bypass.
  - start=0 -> IDLE next cycle. Pipeline valids are flushed the same cycle; no output issues after start falls.
- Focal zones:
  - Zone sample counter counts acc up to ZONE_LEN-1, then wraps.
  - On wrap, zone_idx increments, saturating at 2^ADDR_WD-1, and LUT[zone_idx+1] is fetched.
  - The new D applies from the first sample of the new zone.
  - D may increase or decrease; the buffer holds the history.
  - LUT read path has a 1-cycle prefetch: the next zone's delay is read when the counter equals ZONE_LEN-2.
- LUT write/read collision: same address in the same cycle is read-first (old value). Writes during RUN are permitted and take effect at the next fetch of that address.
- Pipeline (tx_en=0 continuous, fill > D):
  - Sample x accepted at cycle t.
  - cd_dout = x[t-D] at t+1.
  - Product registered at t+2, using apo_din sampled at t.
  - dbf_ch_dout at t+3: dbf_ch_dout = sat_OUT_WD((x[t-D]*apo[t] + 2^(SHIFT-1)) >>> SHIFT). Arithmetic shift; round half up; saturate to [-2^(OUT_WD-1), 2^(OUT_WD-1)-1].
- tx_en high in RUN: no accept, pointers and counters hold, a bubble propagates (valid=0), data outputs hold last value.
- Invalid cycles: dbf_ch_dout holds its last value.

Decomposition:
- Shared package/include (extend param.h/define.v): width defaults, FSM state encodings (IDLE/LOAD/RUN), sat/round helper function.
- One sub-module: dbf_delay_ram, a simple dual-port sync RAM with read-first mode. Instantiated twice: sample buffer (2^DLY_WD x INPUT_WD) and delay LUT (2^ADDR_WD x DLY_WD).
- FSM, counters and apodisation pipeline stay in dbf_chan_dynfocus.

Test Plan:
- Fixed delay:
  - Stimulus: LUT all =5, apo=0x7FFF, ramp ch_in=0,1,2..., start=1, tx_en=0.
  - Expected: first valid 3 cycles after the 6th accepted sample; output sequence 0,1,2... ((x*32767+16384)>>>15 gives x for small x); cd_dout tracks at 1 cycle earlier.
- Zone switch:
  - Stimulus: ZONE_LEN=64, LUT[0]=10, LUT[1]=4.
  - Expected: sample 64 output = x[60]; zone_idx=1 from the 64th accept; zone_idx saturates at 63 after 64*64 samples.
- Saturation/rounding:
  - Stimulus: ch_in=8191, apo=32767, OUT_WD=12.
  - Expected: out=2047 (saturated).
  - Stimulus: ch_in=-8192, apo=32767.
  - Expected: out=-2048.
  - Stimulus: ch_in=1, apo=16384.
  - Expected: out=1 (rounded).
- tx_en gaps:
  - Stimulus: toggle tx_en every 3 cycles with D=2.
  - Expected: valids only for accepted samples; delayed data ordering is intact; counters freeze during tx_en.
- Abort/reset:
  - Stimulus: drop start mid-line.
  - Expected: valid=0 the next cycle; next start restarts at zone 0 with an empty fill.
  - Stimulus: assert rst_n=0 asynchronously mid-line.
  - Expected: all outputs 0 immediately.
- LUT collision:
  - Stimulus: lut_we to address 1 in the same cycle as the prefetch of zone 1.
  - Expected: old value used; new value used on the next line.
